// File: rtl/trap_pkg.sv
// trap_pkg: shared trap sprite types, default geometry and the shift-add address helper
package trap_pkg;

  typedef enum logic [1:0] {
    HIDDEN     = 2'd0,
    RISING     = 2'd1,
    EXTENDED   = 2'd2,
    RETRACTING = 2'd3
  } trap_state_e;

  localparam int          SPR_W_DEF     = 21;
  localparam int          SPR_H_DEF     = 21;
  localparam logic [11:0] KEY_COLOR_DEF = 12'h808;
  localparam int          ADDR_W        = 9;

  // Constant multiply built from shifted copies of a; k is a parameter so the
  // unused terms fold away and only adders for the set bits of k remain.
  function automatic logic [ADDR_W-1:0] mul_const(input logic [ADDR_W-1:0] a, input int k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++)
      if (k[i]) acc = acc + (a << i);
    return acc;
  endfunction

endpackage

// File: rtl/trap_anim_fsm.sv
// trap_anim_fsm: frame-driven spike animation (hidden, rising, extended, retracting) with lethal flag
module trap_anim_fsm
  import trap_pkg::*;
#(
  parameter int SPR_H       = SPR_H_DEF,
  parameter int HIDE_FRAMES = 60,
  parameter int EXT_FRAMES  = 30,
  parameter int STEP_FRAMES = 1,
  parameter int LETHAL_OFS  = 10,
  parameter int OW          = $clog2(SPR_H + 1)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          enable,
  input  logic          frame_start,
  output logic [OW-1:0] offset,
  output logic          lethal,
  output trap_state_e   state
);

  localparam int MAXA = HIDE_FRAMES > EXT_FRAMES ? HIDE_FRAMES : EXT_FRAMES;
  localparam int MAXF = MAXA > STEP_FRAMES ? MAXA : STEP_FRAMES;
  localparam int CW   = $clog2(MAXF + 1);

  trap_state_e   r_state, w_state;
  logic [OW-1:0] r_offset, w_offset;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_lethal;
  logic          w_step;

  assign w_step = r_cnt == CW'(STEP_FRAMES - 1);

  // Next-state: enable low forces the idle pose and outranks frame_start;
  // otherwise the animation only moves on a frame pulse, and every state
  // change clears the per-state frame counter.
  always_comb begin
    w_state  = r_state;
    w_offset = r_offset;
    w_cnt    = r_cnt;
    if (!enable) begin
      w_state  = HIDDEN;
      w_offset = OW'(SPR_H);
      w_cnt    = '0;
    end else if (frame_start) begin
      w_cnt = r_cnt + 1'b1;
      case (r_state)
        HIDDEN: if (r_cnt == CW'(HIDE_FRAMES - 1)) begin
          w_state = RISING;
          w_cnt   = '0;
        end
        RISING: if (w_step) begin
          w_cnt    = '0;
          w_offset = r_offset - 1'b1;
          if (r_offset == OW'(1)) w_state = EXTENDED;
        end
        EXTENDED: if (r_cnt == CW'(EXT_FRAMES - 1)) begin
          w_state = RETRACTING;
          w_cnt   = '0;
        end
        default: if (w_step) begin
          w_cnt    = '0;
          w_offset = r_offset + 1'b1;
          if (r_offset == OW'(SPR_H - 1)) w_state = HIDDEN;
        end
      endcase
    end
  end

  // State registers; lethal samples the offset already committed, so it trails an offset change by one clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= HIDDEN;
      r_offset <= OW'(SPR_H);
      r_cnt    <= '0;
      r_lethal <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_offset <= w_offset;
      r_cnt    <= w_cnt;
      r_lethal <= enable && r_offset <= OW'(LETHAL_OFS);
    end
  end

  assign offset = r_offset;
  assign lethal = r_lethal;
  assign state  = r_state;

endmodule

// File: rtl/trap_sprite_renderer.sv
// trap_sprite_renderer: maps scan position to trap ROM addresses and pipelines the color for the mapper
module trap_sprite_renderer
  import trap_pkg::*;
#(
  parameter int          SPR_W       = SPR_W_DEF,
  parameter int          SPR_H       = SPR_H_DEF,
  parameter int          HIDE_FRAMES = 60,
  parameter int          EXT_FRAMES  = 30,
  parameter int          STEP_FRAMES = 1,
  parameter int          LETHAL_OFS  = 10,
  parameter logic [11:0] KEY_COLOR   = KEY_COLOR_DEF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic        frame_start,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  trap_x,
  input  logic [9:0]  trap_y,
  output logic [8:0]  read_address,
  input  logic [11:0] rom_color,
  output logic [11:0] pixel_color,
  output logic        pixel_on,
  output logic        lethal,
  output logic [1:0]  state_dbg
);

  localparam int OW = $clog2(SPR_H + 1);

  trap_state_e        w_state;
  logic [OW-1:0]      w_offset;
  logic signed [10:0] w_relx, w_rely, w_srow;
  logic               w_hit;
  logic [8:0]         w_addr;
  logic [8:0]         r_addr;
  logic               r_hit_q;
  logic [11:0]        r_color;
  logic               r_on;

  trap_anim_fsm #(
    .SPR_H      (SPR_H),
    .HIDE_FRAMES(HIDE_FRAMES),
    .EXT_FRAMES (EXT_FRAMES),
    .STEP_FRAMES(STEP_FRAMES),
    .LETHAL_OFS (LETHAL_OFS),
    .OW         (OW)
  ) u_anim (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .frame_start(frame_start),
    .offset     (w_offset),
    .lethal     (lethal),
    .state      (w_state)
  );

  // Positions are zero-extended before subtracting so a sprite hanging off
  // the left/top edge gives a negative delta instead of a wrapped hit.
  assign w_relx = $signed({1'b0, DrawX}) - $signed({1'b0, trap_x});
  assign w_rely = $signed({1'b0, DrawY}) - $signed({1'b0, trap_y});
  assign w_srow = w_rely - $signed({{(11 - OW){1'b0}}, w_offset});
  assign w_hit  = w_relx >= 11'sd0 && w_relx < $signed(11'(SPR_W)) &&
                  w_rely >= 11'sd0 && w_rely < $signed(11'(SPR_H)) &&
                  w_srow >= 11'sd0;
  assign w_addr = w_hit ? mul_const(w_srow[8:0], SPR_W) + w_relx[8:0] : 9'd0;

  // Stage 1: ROM address and hit flag for the current scan position.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_addr  <= '0;
      r_hit_q <= 1'b0;
    end else begin
      r_addr  <= w_addr;
      r_hit_q <= w_hit;
    end
  end

  // Stage 2: capture the ROM color every cycle; visibility masks out the key color.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_color <= '0;
      r_on    <= 1'b0;
    end else begin
      r_color <= rom_color;
      r_on    <= r_hit_q && rom_color != KEY_COLOR;
    end
  end

  assign read_address = r_addr;
  assign pixel_color  = r_color;
  assign pixel_on     = r_on;
  assign state_dbg    = w_state;

endmodule

// File: doc/trap_sprite_renderer.md
Name: trap_sprite_renderer

Overview:
- Reader side of the 21x21 trap sprite ROM (441 palette-indexed entries, 12-bit RGB out).
- Converts the VGA scan position and the trap's world position into ROM read addresses and pipelines the returned color into a pixel/valid pair for the color mapper.
- Runs a frame-driven spike animation FSM: hidden, rising, extended, retracting. Exports a lethal flag for Mario collision logic.

Parameters:
- SPR_W, 21, sprite width in pixels
- SPR_H, 21, sprite height in pixels (SPR_W*SPR_H <= 512)
- HIDE_FRAMES, 60, frames spent fully retracted
- EXT_FRAMES, 30, frames held fully extended
- STEP_FRAMES, 1, frames per 1-pixel rise/retract step
- LETHAL_OFS, 10, trap is lethal while offset <= this value
- KEY_COLOR, 12'h808, transparent palette color

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- enable  in  1  trap animation enabled (level)
- frame_start  in  1  one-cycle pulse per frame (vsync edge)
- DrawX  in  10  current scan column
- DrawY  in  10  current scan row
- trap_x  in  10  screen X of sprite left edge
- trap_y  in  10  screen Y of sprite top edge (ground line = trap_y+SPR_H-1)
- read_address  out  9  ROM read address
- rom_color  in  12  ROM output color (combinational from read_address)
- pixel_color  out  12  trap color for this pixel
- pixel_on  out  1  trap pixel visible and opaque
- lethal  out  1  trap currently harmful
- state_dbg  out  2  FSM state encoding

Behaviour:
- Reset (async, Reset_n=0): state=HIDDEN, offset=SPR_H, frame_cnt=0, read_address=0, hit_q=0, pixel_color=0, pixel_on=0, lethal=0.
- Stage 1 (registered at edge after inputs):
  - relx = DrawX - trap_x and rely = DrawY - trap_y, both 11-bit signed.
  - hit = 0<=relx<SPR_W and 0<=rely<SPR_H and rely>=offset.
  - srow = rely - offset.
  - read_address <= hit ? srow*SPR_W + relx : 0. The multiply is implemented as shift-add; max address 440.
  - hit_q <= hit.
- Stage 2: pixel_color <= rom_color; pixel_on <= hit_q && rom_color != KEY_COLOR.
- Latency: 2 Clk from DrawX/DrawY to pixel_on/pixel_color. Consumers delay DrawX/DrawY to match.
- pixel_color updates every cycle, including when pixel_on=0. Consumers must gate with pixel_on.
- FSM advances only on frame_start. frame_cnt counts frame_start pulses within a state and clears on every transition.
  - HIDDEN (0): offset=SPR_H. Goes to RISING when frame_cnt reaches HIDE_FRAMES-1 on a frame_start.
  - RISING (1): each STEP_FRAMES pulses, offset -= 1. Goes to EXTENDED on the pulse that makes offset 0.
  - EXTENDED (2): offset=0. Goes to RETRACTING after EXT_FRAMES pulses.
  - RETRACTING (3): each STEP_FRAMES pulses, offset += 1. Goes to HIDDEN on the pulse that makes offset SPR_H.
- enable=0 (synchronous): state=HIDDEN, offset=SPR_H, frame_cnt=0 on the next Clk. This takes priority over frame_start in the same cycle.
- lethal is registered: lethal <= enable && offset <= LETHAL_OFS, evaluated on the post-update offset. It therefore settles one cycle after the offset changes.
- offset changes only on frame_start. Mid-frame tearing is impossible given vsync timing.
- Boundary handling:
  - Sprite partially off-screen: relx/rely are computed signed, so there is no false hit from unsigned wrap.
  - trap_x > DrawX: relx is negative, so no hit.
  - offset=SPR_H: no rows visible.
- Reset mid-frame: outputs clear immediately. The animation restarts in HIDDEN.

Decomposition:
- Shared package trap_pkg:
  - trap_state_e enum (HIDDEN=2'd0, RISING=2'd1, EXTENDED=2'd2, RETRACTING=2'd3).
  - SPR_W/SPR_H defaults and KEY_COLOR constant, reused by other sprite renderers.
- One natural sub-module: trap_anim_fsm. It holds the state, offset and frame_cnt and outputs offset and lethal. The renderer top holds the address/color pipeline.
- The ROM is instantiated outside this block. The bench uses a behavioral ROM model.

Test Plan:
- Reset_n=0 mid-scan with pixel_on=1 -> pixel_on=0, read_address=0, state_dbg=0 immediately. After release the FSM stays HIDDEN until 60 frame_start pulses.
- enable=1, STEP_FRAMES=1, pulse frame_start continuously:
  - 60 pulses -> RISING.
  - 21 further pulses -> EXTENDED, offset=0.
  - 30 pulses -> RETRACTING.
  - 21 pulses -> HIDDEN.
  - lethal rises when offset reaches 10 and falls when offset reaches 11.
- EXTENDED, trap_x=100, trap_y=200, DrawX=110, DrawY=205 -> read_address=115 one cycle later. Two cycles later pixel_color equals ROM[115] and pixel_on=1 if ROM[115] != 12'h808.
- EXTENDED, DrawX=120, DrawY=220 -> read_address=440. DrawX=121 or DrawX=99 -> pixel_on=0. ROM entry 12'h808 inside the box -> pixel_on=0.
- RISING with offset=15, trap_y=200: DrawY=214 -> pixel_on=0. DrawY=215, DrawX=trap_x -> read_address=0. DrawY=220, DrawX=trap_x -> read_address=105.
- trap_x=5, DrawX=2 (relx=-3) -> no hit. enable dropped during RISING with a simultaneous frame_start -> next cycle state=HIDDEN, offset=21, lethal=0.
